// File: rtl/esp8266_uart_tx.sv
// Byte-strobe UART transmitter: captures Data_send on each Sig rise into a FIFO
// and shifts bytes out as 8N1 frames on Tx, flagging dropped bytes in Overflow.
module esp8266_uart_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 16
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Sig,
  input  logic [7:0]             Data_send,
  output logic                   Tx,
  output logic                   Busy,
  output logic                   Tx_done,
  output logic                   Fifo_full,
  output logic [$clog2(DEPTH):0] Fifo_count,
  output logic                   Overflow
);

  // state | meaning
  // IDLE  | line high, waiting for a byte in the FIFO
  // START | start bit (low) for DIV cycles
  // DATA  | eight data bits, LSB first, DIV cycles each
  // STOP  | stop bit (high); Tx_done in its last cycle, may chain to START

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BAUD_PRE  = CW'(DIV - 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          s1, s2, s3;
  logic          push, push_ok, pop;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [7:0]    mem [DEPTH];
  logic          empty;
  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          baud_last;

  assign push      = s2 & ~s3;
  assign empty     = (wr_ptr == rd_ptr);
  assign Fifo_full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  // A full FIFO drops the push even if the FSM frees a slot in the same cycle.
  assign push_ok   = push & ~Fifo_full;
  assign baud_last = (baud_cnt == BAUD_LAST);
  assign pop       = ~empty & ((state == IDLE) | ((state == STOP) & baud_last));

  assign Fifo_count = wr_ptr - rd_ptr;
  assign Busy       = (state != IDLE) | ~empty;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= Sig;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge Clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= Data_send;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push & Fifo_full) Overflow <= 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      Tx       <= 1'b1;
      Tx_done  <= 1'b0;
    end else begin
      // Registered, so it is raised one cycle early to land on the last STOP cycle.
      Tx_done <= (state == STOP) && (baud_cnt == BAUD_PRE);
      case (state)
        IDLE: begin
          Tx       <= 1'b1;
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (pop) begin
            shift <= mem[rd_ptr[AW-1:0]];
            Tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            Tx       <= shift[0];
            shift    <= {1'b0, shift[7:1]};
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              Tx    <= 1'b1;
              state <= STOP;
            end else begin
              Tx      <= shift[0];
              shift   <= {1'b0, shift[7:1]};
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr[AW-1:0]];
              Tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          Tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_esp8266_uart_tx.sv
// Bench for esp8266_uart_tx: a line decoder rebuilds bytes from Tx and
// compares them with the queue of bytes pushed by the directed/random steps.
module tb_esp8266_uart_tx;
  localparam int CLK_FREQ = 1_843_200;
  localparam int BAUD     = 115200;
  localparam int DEPTH    = 16;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * DIV;

  logic       Clk, Rst, Sig;
  logic [7:0] Data_send;
  logic       Tx, Busy, Tx_done, Fifo_full, Overflow;
  logic [4:0] Fifo_count;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] rx_q[$];
  int         st_q[$];
  logic [7:0] exp_q[$];

  esp8266_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst), .Sig(Sig), .Data_send(Data_send),
    .Tx(Tx), .Busy(Busy), .Tx_done(Tx_done), .Fifo_full(Fifo_full),
    .Fifo_count(Fifo_count), .Overflow(Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line decoder: one frame is FRAME negedge samples starting at the first low sample.
  logic [7:0] dec_b;
  bit         dec_good, dec_abort;
  int         dec_s, dec_slot;
  initial begin : decoder
    forever begin
      @(negedge Clk);
      if (Rst === 1'b0 && Tx === 1'b0) begin
        dec_s = cyc; dec_good = 1; dec_abort = 0; dec_b = '0;
        if (Tx_done !== 1'b0) dec_good = 0;
        for (int k = 1; k < FRAME; k++) begin
          @(negedge Clk);
          if (Rst !== 1'b0) begin
            dec_abort = 1;
            break;
          end
          dec_slot = k / DIV;
          if (dec_slot == 0) begin
            if (Tx !== 1'b0) dec_good = 0;
          end else if (dec_slot == 9) begin
            if (Tx !== 1'b1) dec_good = 0;
          end else if (k % DIV == 0) begin
            dec_b[dec_slot-1] = Tx;
          end else if (Tx !== dec_b[dec_slot-1]) begin
            dec_good = 0;
          end
          if (Tx_done !== (k == FRAME - 1)) dec_good = 0;
        end
        if (!dec_abort) begin
          check("frame_shape", {31'd0, dec_good}, 32'd1);
          rx_q.push_back(dec_b);
          st_q.push_back(dec_s);
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_byte(input logic [7:0] b, input int hi, input int lo);
    Data_send = b;
    Sig = 1'b1;
    repeat (hi) @(negedge Clk);
    Sig = 1'b0;
    repeat (lo) @(negedge Clk);
  endtask

  task automatic wait_rx(input int n, input int budget);
    int t;
    t = 0;
    while (rx_q.size() < n && t < budget) begin
      @(negedge Clk);
      t++;
    end
    check("rx_count", rx_q.size(), n);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge Clk);
  endtask

  task automatic clear_rx();
    rx_q.delete();
    st_q.delete();
    exp_q.delete();
  endtask

  string msg = "m(\"23.5\",\"45\",\"67\")\r\n\n";
  int c0, s0, n_b;
  logic [7:0] rb;

  initial begin : stim
    Rst = 1'b1; Sig = 1'b0; Data_send = 8'h00;
    repeat (3) @(negedge Clk);
    check("rst_tx", Tx, 1);
    check("rst_busy", Busy, 0);
    check("rst_done", Tx_done, 0);
    check("rst_full", Fifo_full, 0);
    check("rst_count", Fifo_count, 0);
    check("rst_ovf", Overflow, 0);
    Rst = 1'b0;
    repeat (3) @(negedge Clk);

    // Single byte: latency, level and pulse timing
    clear_rx();
    c0 = cyc;
    Data_send = 8'h6D; Sig = 1'b1;
    @(negedge Clk); Sig = 1'b0;
    wait_cyc(c0 + 3);
    check("single_count_pushed", Fifo_count, 1);
    check("single_tx_before", Tx, 1);
    check("single_busy", Busy, 1);
    wait_cyc(c0 + 4);
    check("single_tx_fall", Tx, 0);
    check("single_count_popped", Fifo_count, 0);
    wait_rx(1, FRAME + 50);
    if (rx_q.size() > 0) begin
      check("single_byte", rx_q[0], 8'h6D);
      check("single_start", st_q[0], c0 + 4);
    end
    @(negedge Clk);
    check("single_busy_after", Busy, 0);
    check("single_count_after", Fifo_count, 0);

    // Full encoder message at a strobe period longer than a frame
    clear_rx();
    for (int i = 0; i < msg.len(); i++) begin
      exp_q.push_back(msg[i]);
      push_byte(msg[i], 5, FRAME + 35);
    end
    wait_rx(exp_q.size(), 2 * FRAME);
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) check("msg_byte", rx_q[i], exp_q[i]);
    check("msg_ovf", Overflow, 0);

    // Random bursts that never exceed the FIFO
    clear_rx();
    for (int burst = 0; burst < 3; burst++) begin
      n_b = $urandom_range(1, DEPTH);
      for (int i = 0; i < n_b; i++) begin
        rb = 8'($urandom_range(0, 255));
        exp_q.push_back(rb);
        push_byte(rb, $urandom_range(1, 3), $urandom_range(3, 6));
      end
      check("rand_count", Fifo_count, n_b - 1);
      check("rand_busy", Busy, 1);
      wait_rx(exp_q.size(), (n_b + 1) * FRAME);
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) check("rand_byte", rx_q[i], exp_q[i]);
    check("rand_ovf", Overflow, 0);
    repeat (5) @(negedge Clk);

    // Long strobe yields exactly one frame
    clear_rx();
    push_byte(8'hA5, 3000, 4 * FRAME);
    check("long_frames", rx_q.size(), 1);
    if (rx_q.size() > 0) check("long_byte", rx_q[0], 8'hA5);

    // Push lands on the STOP->START pop with three bytes buffered
    clear_rx();
    c0 = cyc;
    s0 = c0 + 4;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h30 + 8'(i));
      push_byte(8'h30 + 8'(i), 1, 2);
    end
    exp_q.push_back(8'hEE);
    wait_cyc(s0 + FRAME - 3);
    Data_send = 8'hEE; Sig = 1'b1;
    @(negedge Clk); Sig = 1'b0;
    wait_cyc(s0 + FRAME - 1);
    check("simul_done", Tx_done, 1);
    check("simul_count_before", Fifo_count, 3);
    wait_cyc(s0 + FRAME);
    check("simul_count_after", Fifo_count, 3);
    check("simul_tx_start", Tx, 0);
    wait_rx(5, 6 * FRAME);
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) check("simul_byte", rx_q[i], exp_q[i]);

    // Overflow: 18 strobes 8 cycles apart
    clear_rx();
    repeat (5) @(negedge Clk);
    for (int i = 0; i < 18; i++) push_byte(8'(i), 1, 7);
    check("ovf_full", Fifo_full, 1);
    check("ovf_count", Fifo_count, DEPTH);
    check("ovf_flag", Overflow, 1);
    wait_rx(17, 18 * FRAME);
    for (int i = 0; i < rx_q.size(); i++) check("ovf_byte", rx_q[i], 8'(i));
    for (int i = 1; i < st_q.size(); i++) check("ovf_spacing", st_q[i] - st_q[i-1], FRAME);
    repeat (2 * FRAME) @(negedge Clk);
    check("ovf_extra", rx_q.size(), 17);
    check("ovf_sticky", Overflow, 1);
    check("ovf_full_after", Fifo_full, 0);

    // Reset during data bit 3
    clear_rx();
    c0 = cyc;
    s0 = c0 + 4;
    push_byte(8'h3C, 1, 2);
    wait_cyc(s0 + 4 * DIV + DIV / 2);
    #1 Rst = 1'b1;
    #1;
    check("mrst_tx", Tx, 1);
    check("mrst_busy", Busy, 0);
    check("mrst_done", Tx_done, 0);
    check("mrst_full", Fifo_full, 0);
    check("mrst_count", Fifo_count, 0);
    check("mrst_ovf", Overflow, 0);
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    repeat (2 * FRAME) @(negedge Clk);
    check("mrst_frames", rx_q.size(), 0);
    check("mrst_tx_idle", Tx, 1);
    check("mrst_busy_idle", Busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/esp8266_uart_tx.md
# esp8266_uart_tx

Serial transmitter directly downstream of the ESP8266 message encoder. It accepts one byte per rising edge of the encoder's `Sig` strobe, buffers bytes in a small FIFO, and shifts them out as 8N1 UART frames on `Tx` toward the ESP8266 module. It decouples the encoder's fixed strobe cadence from the line baud rate and flags any dropped bytes.

## Interface
- `CLK_FREQ`, default 50_000_000: `Clk` frequency in Hz.
- `BAUD`, default 115200: line rate. `DIV = CLK_FREQ/BAUD`, truncated (434 at the defaults). `DIV` must be ≥ 2.
- `DEPTH`, default 16: FIFO depth in bytes. Must be a power of two.
- `Clk` input, 1 bit: system clock. All logic is on its rising edge.
- `Rst` input, 1 bit: asynchronous, active-high reset.
- `Sig` input, 1 bit: byte strobe from the encoder. Only its rising edge is significant.
- `Data_send` input, 8 bits: byte from the encoder. Stable from ≤1 cycle after the `Sig` rise until the next rise.
- `Tx` output, 1 bit: UART line. Idles high.
- `Busy` output, 1 bit: high while a frame is on the line or the FIFO is non-empty.
- `Tx_done` output, 1 bit: one-cycle pulse at the end of each stop bit.
- `Fifo_full` output, 1 bit: FIFO holds `DEPTH` bytes.
- `Fifo_count` output, log2(DEPTH)+1 bits: current FIFO occupancy.
- `Overflow` output, 1 bit: sticky. Set when a byte is dropped; cleared only by `Rst`.

## Operation
- **Strobe capture:** `Sig` passes through three flops (`s1`, `s2`, `s3`). A push occurs when `s2 & ~s3`. `Data_send` is written into the FIFO in that same cycle. A `Sig` held high for any length produces exactly one push.
- **FIFO:** circular buffer with read/write pointers of log2(DEPTH)+1 bits. Empty when the pointers are equal. Full when the indices are equal and the MSBs differ.
  - A push while `Fifo_full` is dropped, even if a pop occurs in the same cycle. The drop sets `Overflow`.
  - A simultaneous push and pop on a non-full, non-empty FIFO leaves `Fifo_count` unchanged.
- **Transmit FSM states:** IDLE, START, DATA, STOP. A baud counter counts 0..DIV-1, and a bit index counts 0..7.
  - IDLE: `Tx`=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `Tx`=0 for DIV cycles, then go to DATA.
  - DATA: `Tx` = shift[0], LSB first. Each bit lasts DIV cycles. Shift right and advance the bit index. After bit 7, go to STOP.
  - STOP: `Tx`=1 for DIV cycles. In the last cycle, pulse `Tx_done`. If the FIFO is non-empty, pop and go to START with no idle gap; otherwise go to IDLE.
- `Busy` = (state ≠ IDLE) | FIFO non-empty.
- **Reset (any time, including mid-frame):** outputs are forced immediately to `Tx`=1, `Busy`=0, `Tx_done`=0, `Fifo_full`=0, `Fifo_count`=0, `Overflow`=0. The FSM returns to IDLE, pointers and counters clear, and sync flops clear. A partially sent frame is abandoned.

## Timing
- Push latency: `Sig` is first sampled high at edge N; the FIFO write occurs at edge N+2.
- Start latency: FIFO becomes non-empty at edge E → pop at edge E+1 → `Tx` falls after edge E+1. A lone byte therefore starts `Tx` falling after edge N+3.
- Frame length: exactly 10·DIV cycles from the `Tx` fall to the end of the stop bit (4340 cycles at the defaults).
- `Tx_done` is high in the final cycle of STOP. In back-to-back frames, the next start bit begins on the following cycle.
- Throughput: one byte per 10·DIV cycles. The encoder's 5000-cycle strobe period exceeds 4340, so the defaults never overflow in steady state.

## Test plan
- **Single byte:** 0x6D ("m") with a single `Sig` pulse → `Tx` low 434 cycles, then bits 1,0,1,1,0,1,1,0 at 434 cycles each, then high. `Tx_done` pulses 4340 cycles after the `Tx` fall. `Fifo_count` returns to 0 and `Busy` drops after the pulse.
- **Full message:** the encoder's 22-byte sequence "m(\"23.5\",\"45\",\"67\")\r\n\n" at a 5000-cycle strobe → the decoded line matches byte for byte, and `Overflow` stays 0.
- **Overflow:** 18 strobes spaced 8 cycles apart, bytes 0x00..0x11 → 1 byte transmitting, 16 buffered, `Fifo_full`=1, byte 0x11 dropped, `Overflow`=1 and it stays 1. Bytes 0x00..0x10 come out in order, back-to-back.
- **Long strobe:** `Sig` held high for 3000 cycles with 0xA5 → exactly one 0xA5 frame.
- **Mid-frame reset:** `Rst` asserted during bit 3 of a frame → `Tx`=1 and all outputs at their reset values immediately. After release, an idle line with no frame continuation.
- **Simultaneous push/pop:** a strobe lands in the same cycle as the STOP→START pop, with the FIFO holding 3 bytes → `Fifo_count` stays 3 and frame order is preserved.
